// File: rtl/beta_exe_lsu.sv
// beta_exe_lsu -- execute-stage load/store unit.
//
// Runs one data-memory transaction per rising edge of lsu_en_i over a
// req/gnt/rvalid bus. It formats store byte lanes and sign/zero-extends
// load data. Misaligned or illegal-size accesses never reach the bus; they
// are reported on lsu_err_o[1]. Bus errors are reported on lsu_err_o[0].
//
// Ports
//   clk_i, rst_i         clock, async active-high reset
//   lsu_en_i             start request (rising edge)
//   lsu_op_i             0 load, 1 store
//   lsu_op_size_i        00 byte, 01 half, 10 word, 11 reserved
//   lsu_unsigned_i       zero-extend loads
//   lsu_addr_i           effective address
//   lsu_wdata_i          store data, right-aligned
//   lsu_busy_o           operation in progress (registered)
//   lsu_rdata_o          extended load result, held until next start
//   lsu_err_o            {misaligned/illegal, bus error}, held until next start
//   data_*               registered memory bus request / response
module beta_exe_lsu #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_en_i,
  input  logic                 lsu_op_i,
  input  logic [1:0]           lsu_op_size_i,
  input  logic                 lsu_unsigned_i,
  input  logic [AddrWidth-1:0] lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_busy_o,
  output logic [DataWidth-1:0] lsu_rdata_o,
  output logic [1:0]           lsu_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic                 data_we_o,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic [3:0]           data_be_o,
  output logic [DataWidth-1:0] data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [DataWidth-1:0] data_rdata_i,
  input  logic                 data_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_e;

  state_e               state_q, state_d;
  logic                 en_q;
  logic                 start;
  logic                 misal;
  logic                 op_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [1:0]           off_q;
  logic [3:0]           be_d;
  logic [DataWidth-1:0] wdata_d;
  logic [DataWidth-1:0] sh;
  logic [DataWidth-1:0] ld_fmt;

  // Edge detect: a level held high never re-triggers, and edges seen while
  // busy are dropped rather than queued.
  assign start = lsu_en_i & ~en_q & (state_q == IDLE);

  always_comb begin
    misal   = 1'b0;
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    unique case (lsu_op_size_i)
      2'b00: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        misal   = lsu_addr_i[0];
        be_d    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      2'b10: misal = |lsu_addr_i[1:0];
      default: misal = 1'b1;
    endcase
  end

  // Load alignment uses the offset/size latched at start, not the live inputs.
  always_comb begin
    sh     = data_rdata_i >> {off_q, 3'b000};
    ld_fmt = data_rdata_i;
    case (size_q)
      2'b00:   ld_fmt = {{(DataWidth-8){sh[7] & ~uns_q}}, sh[7:0]};
      2'b01:   ld_fmt = {{(DataWidth-16){sh[15] & ~uns_q}}, sh[15:0]};
      default: ld_fmt = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = misal ? ERR : REQ;
      REQ:  if (data_gnt_i) state_d = WAIT;
      WAIT: if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      op_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      lsu_busy_o   <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_err_o    <= 2'b00;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_addr_o  <= '0;
      data_be_o    <= 4'b0000;
      data_wdata_o <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= lsu_en_i;
      lsu_busy_o <= (state_d != IDLE);
      if (start) begin
        op_q      <= lsu_op_i;
        size_q    <= lsu_op_size_i;
        uns_q     <= lsu_unsigned_i;
        off_q     <= lsu_addr_i[1:0];
        lsu_err_o <= 2'b00;
        if (!misal) begin
          data_req_o   <= 1'b1;
          data_we_o    <= lsu_op_i;
          data_addr_o  <= {lsu_addr_i[AddrWidth-1:2], 2'b00};
          data_be_o    <= be_d;
          data_wdata_o <= wdata_d;
        end
      end
      case (state_q)
        // Grant wins over a same-cycle rvalid; the response is taken in WAIT.
        REQ: if (data_gnt_i) data_req_o <= 1'b0;
        WAIT: if (data_rvalid_i) begin
          lsu_err_o[0] <= data_err_i;
          if (!op_q) lsu_rdata_o <= data_err_i ? '0 : ld_fmt;
        end
        ERR: lsu_err_o[1] <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_exe_lsu.sv
module tb_beta_exe_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_en = 1'b0, lsu_op = 1'b0, lsu_uns = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        busy;
  logic [31:0] rdata_o;
  logic [1:0]  err_o;
  logic        req, we;
  logic        gnt = 1'b0, rvalid = 1'b0, berr_i = 1'b0;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  be_o;
  logic [31:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata = '0;

  beta_exe_lsu #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_en_i(lsu_en), .lsu_op_i(lsu_op), .lsu_op_size_i(lsu_size),
    .lsu_unsigned_i(lsu_uns), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_busy_o(busy), .lsu_rdata_o(rdata_o), .lsu_err_o(err_o),
    .data_req_o(req), .data_gnt_i(gnt), .data_we_o(we), .data_addr_o(addr_o),
    .data_be_o(be_o), .data_wdata_o(wdata_o), .data_rvalid_i(rvalid),
    .data_rdata_i(bus_rdata), .data_err_i(berr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte count from size, alignment by modulo, lanes by byte index.
  task automatic do_op(input logic op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gdly, input int rdly,
                       input logic [31:0] rdata, input logic berr);
    int nb, off;
    logic mis;
    logic [3:0] ebe;
    logic [31:0] ewd, ld, mask, sh;
    nb  = 1 << size;
    off = int'(addr % 4);
    mis = (size == 2'b11) || ((addr % nb) != 0);
    ebe = 4'b0000;
    ewd = '0;
    if (!mis) begin
      ebe = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
    lsu_op = op; lsu_size = size; lsu_uns = uns; lsu_addr = addr; lsu_wdata = wdata;
    lsu_en = 1'b1;
    step();
    lsu_en = 1'b0;
    chk("busy_start", 32'(busy), 32'd1);
    if (mis) begin
      chk("mis_noreq", 32'(req), 32'd0);
      step();
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_err", 32'(err_o), 32'd2);
      return;
    end
    for (int g = 0; g <= gdly; g++) begin
      chk("req", 32'(req), 32'd1);
      chk("addr", addr_o, {addr[31:2], 2'b00});
      chk("be", 32'(be_o), 32'(ebe));
      chk("we", 32'(we), 32'(op));
      if (op) chk("wdata", wdata_o, ewd);
      gnt = (g == gdly);
      // rvalid alongside the grant must be ignored
      rvalid = (g == gdly);
      bus_rdata = ~rdata;
      step();
    end
    gnt = 1'b0;
    rvalid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_noreq", 32'(req), 32'd0);
    chk("wait_addr", addr_o, {addr[31:2], 2'b00});
    repeat (rdly) step();
    rvalid = 1'b1; bus_rdata = rdata; berr_i = berr;
    step();
    rvalid = 1'b0; berr_i = 1'b0;
    if (!op) begin
      if (berr) ld = '0;
      else if (nb == 4) ld = rdata;
      else begin
        sh   = rdata >> (8 * off);
        mask = (32'd1 << (8 * nb)) - 32'd1;
        ld   = sh & mask;
        if (!uns && ld[8*nb-1]) ld = ld | ~mask;
      end
      exp_rdata = ld;
    end
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err", 32'(err_o), {30'd0, 1'b0, berr});
    chk("done_rdata", rdata_o, exp_rdata);
  endtask

  initial begin
    int nreq;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_bus", {addr_o[27:0], be_o}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // directed plan
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
    chk("plan_word", rdata_o, 32'hDEADBEEF);
    step();
    do_op(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 3, 0, 32'h0, 1'b0);
    step();
    do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0, 32'h80010000, 1'b0);
    chk("plan_lh", rdata_o, 32'hFFFF8001);
    do_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 1, 32'h80010000, 1'b0);
    chk("plan_lhu", rdata_o, 32'h00008001);
    do_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
    do_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
    do_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1, 0, 32'h12345678, 1'b1);
    chk("plan_berr", rdata_o, 32'h0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'h1000 + $urandom_range(0, 255), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) step();
    end

    // reset while waiting for the response
    do_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0);
    lsu_op = 1'b1; lsu_size = 2'b10; lsu_addr = 32'h404; lsu_wdata = 32'h11223344;
    lsu_en = 1'b1;
    step();
    lsu_en = 1'b0;
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_rdata", rdata_o, 32'd0);
    chk("arst_out", {addr_o[23:0], be_o, 1'b0, we, err_o}, 32'd0);
    chk("arst_wdata", wdata_o, 32'd0);
    rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    rst = 1'b0;
    step();
    rvalid = 1'b0;
    chk("late_rv_busy", 32'(busy), 32'd0);
    chk("late_rv_rdata", rdata_o, 32'd0);
    exp_rdata = '0;

    // a long high level starts exactly one operation; simple responder
    nreq = 0;
    lsu_op = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h500;
    lsu_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) lsu_en = 1'b0;
      gnt = req;
      rvalid = busy & ~req;
      bus_rdata = 32'h0BADF00D;
      if (req) nreq++;
      step();
    end
    gnt = 1'b0;
    rvalid = 1'b0;
    chk("level_one_op", 32'(nreq), 32'd1);
    chk("level_rdata", rdata_o, 32'h0BADF00D);
    chk("level_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/beta_exe_lsu.md
# beta_exe_lsu

Load & Store Unit for the execute stage. It responds to the exe-stage control unit's `en`/`busy` handshake and runs one data-memory transaction per request on a req/gnt/rvalid bus. It formats store byte-lanes, and sign- or zero-extends load data. Misaligned accesses and bus errors are reported to trap detection.

## Interface
Parameters:
- `DataWidth`, 32: data bus width. Only 32 is supported.
- `AddrWidth`, 32: address width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `lsu_en_i` in 1: start request; a rising edge starts one operation.
- `lsu_op_i` in 1: 0 = load, 1 = store.
- `lsu_op_size_i` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `lsu_unsigned_i` in 1: zero-extend loads (LBU/LHU).
- `lsu_addr_i` in AddrWidth: effective address.
- `lsu_wdata_i` in DataWidth: store data, right-aligned.
- `lsu_busy_o` out 1: operation in progress.
- `lsu_rdata_o` out DataWidth: extended load result.
- `lsu_err_o` out 2: bit1 = misaligned/illegal size, bit0 = bus error.
- `data_req_o` out 1: bus request.
- `data_gnt_i` in 1: bus grant.
- `data_we_o` out 1: bus write enable.
- `data_addr_o` out AddrWidth: word-aligned address ({addr[31:2],2'b00}).
- `data_be_o` out 4: byte enables.
- `data_wdata_o` out DataWidth: lane-replicated store data.
- `data_rvalid_i` in 1: response valid.
- `data_rdata_i` in DataWidth: response data.
- `data_err_i` in 1: response error, qualified by `data_rvalid_i`.

## Operation
- Start condition: `start = lsu_en_i & ~en_q & state==IDLE`.
  - `en_q` is `lsu_en_i` registered.
  - A level held high never re-triggers.
  - An edge seen outside IDLE is ignored.
- On start, latch op, size, unsigned, addr[1:0], address and wdata. Clear `lsu_err_o`.
- States:
  - IDLE: on start, go to REQ, or to ERR if misaligned or size==11.
  - REQ: `data_req_o`=1. On `data_gnt_i`, go to WAIT.
  - WAIT: on `data_rvalid_i`, go to IDLE. Capture the load result and set `lsu_err_o[0]`=`data_err_i`.
  - ERR: set `lsu_err_o[1]`. Go to IDLE after one cycle. No bus access.
- Misaligned means any of: half with addr[0]=1, word with addr[1:0]!=00, size 11.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011 if addr[1]=0, else 1100
  - word: 1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load formatting:
  - `sh = data_rdata_i >> (8*addr[1:0])`.
  - Take sh[7:0] for byte or sh[15:0] for half, then sign- or zero-extend per `lsu_unsigned_i`.
  - Word is passed through unchanged.
- Stores do not modify `lsu_rdata_o`.
- A bus error on a load sets `lsu_rdata_o`=0.
- `lsu_rdata_o` and `lsu_err_o` hold until the next start.
- `data_rvalid_i` in IDLE or REQ is ignored.

## Timing
- Reset: state IDLE, `en_q`=0, and every output 0 (`lsu_busy_o`, `lsu_rdata_o`, `lsu_err_o`, `data_req_o`, `data_we_o`, `data_addr_o`, `data_be_o`, `data_wdata_o`).
- `lsu_busy_o` is registered and equals state!=IDLE. It rises the cycle after the start edge.
- Bus outputs are registered. They are valid and stable from REQ entry until the cycle `data_gnt_i` is sampled. After grant, `data_req_o`=0 and the other bus outputs hold.
- Minimum latency, with `lsu_en_i` rising at cycle t, gnt at t+1 and rvalid at t+2:
  - busy=1 at t+1..t+2
  - busy=0 at t+3
  - result valid at t+3
- Error path: busy=1 at t+1 only. `lsu_err_o[1]`=1 from t+2.
- Result and error are valid in the same cycle busy falls, because the CU write-back latches on busy fall.
- `data_gnt_i` and `data_rvalid_i` asserted together in REQ: only the grant is taken; rvalid is ignored. Responses arrive at least one cycle after grant.
- Reset mid-operation: returns to IDLE immediately and drops req. Late rvalid is ignored.
- Back-to-back operations: a new rising edge is accepted the first IDLE cycle after completion.

## Test plan
- Word load at 0x100: gnt at t+1, rvalid at t+2 with 0xDEADBEEF. Expect be=1111, busy high for 2 cycles, `lsu_rdata_o`=0xDEADBEEF at t+3, err=00.
- Byte store at 0x203 with wdata=0x000000A5. Expect addr=0x200, be=1000, `data_wdata_o`=0xA5A5A5A5, we=1. Hold gnt low 3 cycles: bus outputs stable and req held.
- Half load at 0x102 with rdata=0x8001_0000. Signed gives 0xFFFF8001; with `lsu_unsigned_i`=1 gives 0x00008001.
- Word load at 0x101. Expect no req, busy for 1 cycle, `lsu_err_o`=10. Repeat with size=11: same response.
- Load with rvalid and `data_err_i`=1. Expect `lsu_err_o`=01 and `lsu_rdata_o`=0.
- Assert `rst_i` while in WAIT. Expect all outputs 0 asynchronously and rvalid ignored. A subsequent `lsu_en_i` held high for 3 cycles starts exactly one operation.
